draw_sequencer: RTL
===================

Name: draw_sequencer

Overview:
- Parametrised successor to the two-way wall/bird alternator in the game controller.
- Arbitrates VGA draw access among N_CH object controllers (background, walls, bird, future sprites) using a request/grant/done handshake.
- Serves each requesting channel once per frame, in ascending index order, paced by a frame tick.
- Owns game-level sequencing: idle, run, game-over on collision, restart on go.

Parameters:
N_CH, 3, number of draw channels (0 = background, 1 = wall, 2 = bird); min 1, max 8
ID_W, 2, width of grant_id; must satisfy 2^ID_W >= N_CH
FRAME_W, 16, width of the frame counter
TIMEOUT_CYC, 4096, watchdog limit in GRANT cycles (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on its rising edge
resetn  in  1  synchronous, active-low reset
go  in  1  start/restart pulse (player key)
frame_tick  in  1  one-cycle pulse at frame start (vsync-derived)
collision  in  1  level from the collision detector
req  in  N_CH  per-channel draw request, level
done  in  N_CH  per-channel one-cycle completion pulse
grant  out  N_CH  one-hot draw grant, registered
grant_id  out  ID_W  index of the granted channel; valid while grant != 0
cur_state  out  3  FSM state: IDLE=0, WAIT=1, SCAN=2, GRANT=3, OVER=4
frame_cnt  out  FRAME_W  frames started since go; saturates at all-ones
game_over  out  1  high in OVER
overrun  out  1  sticky; frame_tick arrived while SCAN/GRANT was active
timeout_err  out  1  sticky watchdog flag; constant 0 without the macro

Behaviour:
- Reset (resetn=0 at a clock edge) forces:
  - state=IDLE
  - grant=0, grant_id=0, pending=0
  - frame_cnt=0, overrun=0, timeout_err=0, wd counter=0
  - A reset mid-GRANT drops grant on the next edge; no done is required.
- IDLE:
  - go=1 -> WAIT; frame_cnt cleared.
  - frame_tick, req, and collision are ignored.
- WAIT:
  - collision=1 -> OVER (collision has priority over frame_tick).
  - Otherwise frame_tick=1 -> pending <= all ones, frame_cnt increments (saturating), -> SCAN.
- SCAN (exactly one cycle):
  - m = pending & req.
  - collision=1 -> OVER.
  - Else if m==0 -> pending <= 0, -> WAIT.
  - Else idx = lowest set bit of m -> pending[idx] <= 0, grant <= onehot(idx), grant_id <= idx, -> GRANT.
  - A channel not requesting when scanned is skipped for the rest of that frame.
- GRANT:
  - Grant is held until done[idx]=1; done on other channels is ignored.
  - done may arrive in the first GRANT cycle.
  - On done: grant <= 0, then -> OVER if collision was latched during this grant, else -> SCAN.
  - Minimum cost per served channel is 2 cycles (SCAN + GRANT).
  - req[idx] dropping mid-grant does not release the grant.
- OVER:
  - grant=0, game_over=1.
  - frame_cnt is frozen.
  - go=1 -> IDLE.
- frame_tick while in SCAN or GRANT:
  - sets overrun; the tick is discarded and pending is not reloaded.
  - The current frame's service continues.
- Collision in GRANT: latched internally, cleared on leaving GRANT.
- go outside IDLE/OVER is ignored.
- frame_cnt at max stays at max.
- grant is at most one-hot in every cycle; this is an assertion target.

Optional Feature:
- Macro: DRAW_SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs in GRANT and clears on entering GRANT.
  - Reaching TIMEOUT_CYC without done forces grant <= 0, sets timeout_err (sticky until reset), and -> SCAN.
  - A done arriving in the same cycle as the timeout wins; no error is flagged.
- Undefined:
  - No counter; GRANT waits indefinitely.
  - timeout_err is tied to 0.

Decomposition:
- Shared package (draw_pkg):
  - state encodings (IDLE..OVER)
  - channel indices CH_BG=0, CH_WALL=1, CH_BIRD=2
  - default N_CH
- One natural sub-module, lowest_set_pick:
  - parametrised N-bit lowest-set-bit finder
  - outputs a valid flag, the index, and the one-hot vector
  - reusable by other arbiters

Test Plan:
1. Reset then go, frame_tick, req=3'b111, each done 2 cycles after grant -> grants 001, 010, 100 in order; returns to WAIT; frame_cnt=1.
2. req=3'b101 -> wall skipped; grants 001 then 100; grant_id 0 then 2; never 010 that frame.
3. collision asserted mid-grant to channel 1 -> grant held until done[1]; then OVER, game_over=1; later go -> IDLE, frame_cnt=0 on the next go.
4. frame_tick pulsed while grant=010 -> overrun=1; pending not reloaded; frame_cnt unchanged until the next tick in WAIT.
5. resetn=0 during GRANT with done never pulsed -> next cycle grant=0, cur_state=0, all flags 0.
6. DRAW_SEQ_WATCHDOG_EN, TIMEOUT_CYC=8, done withheld -> grant drops after 8 GRANT cycles; timeout_err=1; next channel granted. Without the macro, grant holds for 100+ cycles.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the draw sequencer: FSM state encoding, channel indices, defaults.
package draw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_GRANT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int CH_BG    = 0;
  localparam int CH_WALL  = 1;
  localparam int CH_BIRD  = 2;
  localparam int DEF_N_CH = 3;

endpackage

// File: rtl/draw_sequencer_lowest_set_pick.sv
// Lowest-set-bit finder: valid flag, binary index and one-hot of the lowest set bit of vec.
module lowest_set_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign onehot = vec & (~vec + N'(1));
  assign valid  = |vec;

endmodule

// File: rtl/draw_sequencer.sv
// Frame-paced request/grant/done arbiter for VGA draw channels with game-level sequencing.
// Optional watchdog on stuck grants: define DRAW_SEQ_WATCHDOG_EN.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int ID_W        = 2,
  parameter int FRAME_W     = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               go,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH-1:0]    done,
  output logic [N_CH-1:0]    grant,
  output logic [ID_W-1:0]    grant_id,
  output logic [2:0]         cur_state,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               game_over,
  output logic               overrun,
  output logic               timeout_err
);

  state_t            state;
  logic [N_CH-1:0]   pending;
  logic              coll_lat;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic [N_CH-1:0]   pick_onehot;
  logic [N_CH-1:0]   served_mask;
  logic              done_hit;

`ifdef DRAW_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd;
`else
  assign timeout_err = 1'b0;
`endif

  lowest_set_pick #(.N(N_CH), .W(ID_W)) u_pick (
    .vec    (pending & req),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Clearing everything at or below the served channel makes a skipped
  // (non-requesting) channel stay skipped for the rest of the frame.
  assign served_mask = pick_onehot | (pick_onehot - N_CH'(1));
  assign done_hit    = |(done & grant);
  assign cur_state   = state;

  // NOTE: all state updates use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is only seen at a rising clock edge.
    if (!resetn) begin
      state     <= ST_IDLE;
      pending   <= '0;
      grant     <= '0;
      grant_id  <= '0;
      frame_cnt <= '0;
      game_over <= 1'b0;
      overrun   <= 1'b0;
      coll_lat  <= 1'b0;
`ifdef DRAW_SEQ_WATCHDOG_EN
      wd          <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      if (frame_tick && (state == ST_SCAN || state == ST_GRANT)) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (go) begin
            state     <= ST_WAIT;
            frame_cnt <= '0;
          end
        end

        ST_WAIT: begin
          if (collision) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
          end else if (frame_tick) begin
            pending <= '1;
            if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            state <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (collision) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
          end else if (!pick_valid) begin
            pending <= '0;
            state   <= ST_WAIT;
          end else begin
            pending  <= pending & ~served_mask;
            grant    <= pick_onehot;
            grant_id <= pick_idx;
            coll_lat <= 1'b0;
`ifdef DRAW_SEQ_WATCHDOG_EN
            wd <= '0;
`endif
            state <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (done_hit) begin
            grant    <= '0;
            coll_lat <= 1'b0;
            if (coll_lat || collision) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
            end else begin
              state <= ST_SCAN;
            end
          end
`ifdef DRAW_SEQ_WATCHDOG_EN
          else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
            grant       <= '0;
            coll_lat    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_SCAN;
          end
`endif
          else begin
            if (collision) coll_lat <= 1'b1;
`ifdef DRAW_SEQ_WATCHDOG_EN
            wd <= wd + 1'b1;
`endif
          end
        end

        ST_OVER: begin
          if (go) begin
            state     <= ST_IDLE;
            game_over <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(grant));

  a_param_ok: assert property (@(posedge clk)
    (N_CH >= 1) && (N_CH <= 8) && ((1 << ID_W) >= N_CH) && (TIMEOUT_CYC >= 1));

endmodule
